// File: rtl/alu_decode_pkg.sv
// rtl/alu_decode_pkg.sv - shared encodings, field positions, FSM states and bundle type for the ALU decode stage
package alu_decode_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_COPY = 3'b010;

  localparam int EXT_BIT      = 31;
  localparam int CONST_C_BIT  = 28;
  localparam int OP_HI        = 27;
  localparam int OP_LO        = 25;
  localparam int FORM_BIT     = 24;
  localparam int VEC_HI       = 23;
  localparam int VEC_LO       = 22;
  localparam int IMM_HI_HI    = 21;
  localparam int IMM_HI_LO    = 16;
  localparam int IMM_LO_HI    = 11;
  localparam int COPY_NEG_BIT = 24;
  localparam int COPY_SEL_HI  = 23;
  localparam int COPY_SEL_LO  = 20;
  localparam int SEL_A_LO     = 12;
  localparam int SEL_B_LO     = 8;
  localparam int SEL_C_LO     = 4;
  localparam int SEL_D_LO     = 0;

  localparam logic [3:0] ZERO_REG_CONST = 4'b1010;
  localparam int         MAX_DATA_W     = 32;

  typedef enum logic {
    IDLE,
    EXT_WAIT
  } state_t;

  typedef struct packed {
    logic                  invalid_instruction;
    logic [2:0]            alu_op;
    logic [1:0]            alu_vec_perci;
    logic                  alu_form;
    logic                  const_c;
    logic [MAX_DATA_W-1:0] constant;
    logic [3:0]            zero_reg;
    logic [3:0]            alu_a_select;
    logic [3:0]            alu_b_select;
    logic [3:0]            alu_c_select;
    logic [3:0]            alu_d_select;
    logic [3:0]            alu_y1_select;
    logic [3:0]            alu_y2_select;
    logic [1:0]            alu_write;
    logic                  copy_neg;
    logic [3:0]            copy_select;
  } bundle_t;

  // Add/sub carrying an inline constant: the only form that may request an extension word.
  function automatic logic is_const_addsub(input logic [2:0] op, input logic const_c,
                                           input logic form);
    return ((op == OP_ADD) || (op == OP_SUB)) && const_c && !form;
  endfunction

endpackage

// File: rtl/alu_decode_comb.sv
// rtl/alu_decode_comb.sv - purely combinational field decode of one 32-bit word into a bundle
module alu_decode_comb
  import alu_decode_pkg::*;
(
  input  logic [31:0] instruction,
  output bundle_t     bundle
);

  logic [2:0] op;
  logic       unused_bits;

  assign op          = instruction[OP_HI:OP_LO];
  assign unused_bits = ^instruction[31:29];

  always_comb begin
    bundle               = '0;
    bundle.const_c       = instruction[CONST_C_BIT];
    bundle.alu_op        = op;
    bundle.alu_form      = instruction[FORM_BIT];
    bundle.alu_vec_perci = instruction[VEC_HI:VEC_LO];
    bundle.alu_a_select  = instruction[SEL_A_LO+3:SEL_A_LO];
    bundle.alu_b_select  = instruction[SEL_B_LO+3:SEL_B_LO];
    bundle.alu_c_select  = instruction[SEL_C_LO+3:SEL_C_LO];
    bundle.alu_d_select  = instruction[SEL_D_LO+3:SEL_D_LO];
    bundle.alu_y1_select = bundle.alu_a_select;
    bundle.alu_y2_select = bundle.alu_c_select;
    bundle.alu_write     = {bundle.alu_y2_select != 4'd0, bundle.alu_y1_select != 4'd0};

    if ((op == OP_ADD) || (op == OP_SUB)) begin
      if (is_const_addsub(op, bundle.const_c, bundle.alu_form)) begin
        bundle.zero_reg  = ZERO_REG_CONST;
        bundle.alu_write = 2'b01;
        bundle.constant  = MAX_DATA_W'({instruction[IMM_HI_HI:IMM_HI_LO],
                                        instruction[IMM_LO_HI:0]});
      end else if (bundle.const_c) begin
        bundle.invalid_instruction = 1'b1;
        bundle.alu_write           = 2'b00;
      end
    end else if (op == OP_COPY) begin
      bundle.copy_neg    = instruction[COPY_NEG_BIT];
      bundle.copy_select = instruction[COPY_SEL_HI:COPY_SEL_LO];
    end else begin
      bundle.invalid_instruction = 1'b1;
      bundle.alu_write           = 2'b00;
    end
  end

endmodule

// File: rtl/alu_decode_stage.sv
// rtl/alu_decode_stage.sv - decode stage: field decode, bundle FIFO, invalid counter
// Optional ALU_DECODE_EXT_CONST_EN: bit 31 on a constant add/sub waits for a full-width constant word.
module alu_decode_stage
  import alu_decode_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instruction,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              invalid_instruction,
  output logic [2:0]        alu_op,
  output logic [1:0]        alu_vec_perci,
  output logic              alu_form,
  output logic              const_c,
  output logic [DATA_W-1:0] constant,
  output logic [3:0]        zero_reg,
  output logic [3:0]        alu_a_select,
  output logic [3:0]        alu_b_select,
  output logic [3:0]        alu_c_select,
  output logic [3:0]        alu_d_select,
  output logic [3:0]        alu_Y1_select,
  output logic [3:0]        alu_Y2_select,
  output logic [1:0]        alu_write,
  output logic              copy_neg,
  output logic [3:0]        copy_select,
  output logic [CNT_W-1:0]  err_count,
  output logic              ext_pending
);

  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int COUNT_W = PTR_W + 1;

  bundle_t            dec;
  bundle_t            push_data;
  bundle_t            head;
  bundle_t            mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic               accept, push, pop, full;

  alu_decode_comb u_comb (
    .instruction (instruction),
    .bundle      (dec)
  );

  assign full      = (count_q == COUNT_W'(DEPTH));
  assign in_ready  = !full;
  assign out_valid = (count_q != '0);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  // Gate the head so stale storage never shows while the queue is empty or in reset.
  assign head      = out_valid ? mem_q[rd_ptr_q] : '0;

`ifdef ALU_DECODE_EXT_CONST_EN
  state_t  state_q, state_d;
  bundle_t held_q, held_d;

  always_comb begin
    state_d   = state_q;
    held_d    = held_q;
    push      = 1'b0;
    push_data = dec;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (instruction[EXT_BIT] && is_const_addsub(dec.alu_op, dec.const_c, dec.alu_form)) begin
            state_d = EXT_WAIT;
            held_d  = dec;
          end else begin
            push = 1'b1;
          end
        end
      end
      EXT_WAIT: begin
        if (accept) begin
          push               = 1'b1;
          push_data          = held_q;
          push_data.constant = MAX_DATA_W'(instruction[DATA_W-1:0]);
          state_d            = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      held_q  <= '0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
    end
  end

  assign ext_pending = (state_q == EXT_WAIT);
`else
  assign push        = accept;
  assign push_data   = dec;
  assign ext_pending = 1'b0;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    err_d    = err_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + COUNT_W'(push) - COUNT_W'(pop);
    if (pop && head.invalid_instruction && (err_q != '1)) err_d = err_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign invalid_instruction = head.invalid_instruction;
  assign alu_op              = head.alu_op;
  assign alu_vec_perci       = head.alu_vec_perci;
  assign alu_form            = head.alu_form;
  assign const_c             = head.const_c;
  assign constant            = head.constant[DATA_W-1:0];
  assign zero_reg            = head.zero_reg;
  assign alu_a_select        = head.alu_a_select;
  assign alu_b_select        = head.alu_b_select;
  assign alu_c_select        = head.alu_c_select;
  assign alu_d_select        = head.alu_d_select;
  assign alu_Y1_select       = head.alu_y1_select;
  assign alu_Y2_select       = head.alu_y2_select;
  assign alu_write           = head.alu_write;
  assign copy_neg            = head.copy_neg;
  assign copy_select         = head.copy_select;
  assign err_count           = err_q;

endmodule

// File: tb/tb_alu_decode_stage.sv
// tb/tb_alu_decode_stage.sv - directed self-checking bench for alu_decode_stage (either ALU_DECODE_EXT_CONST_EN build)
module tb_alu_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instruction;
  logic        out_valid;
  logic        out_ready;
  logic        invalid_instruction;
  logic [2:0]  alu_op;
  logic [1:0]  alu_vec_perci;
  logic        alu_form;
  logic        const_c;
  logic [31:0] constant;
  logic [3:0]  zero_reg;
  logic [3:0]  alu_a_select, alu_b_select, alu_c_select, alu_d_select;
  logic [3:0]  alu_Y1_select, alu_Y2_select;
  logic [1:0]  alu_write;
  logic        copy_neg;
  logic [3:0]  copy_select;
  logic [7:0]  err_count;
  logic        ext_pending;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_decode_stage #(.DATA_W(32), .DEPTH(2), .CNT_W(8)) dut (
    .clk                 (clk),
    .reset               (reset),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .instruction         (instruction),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .invalid_instruction (invalid_instruction),
    .alu_op              (alu_op),
    .alu_vec_perci       (alu_vec_perci),
    .alu_form            (alu_form),
    .const_c             (const_c),
    .constant            (constant),
    .zero_reg            (zero_reg),
    .alu_a_select        (alu_a_select),
    .alu_b_select        (alu_b_select),
    .alu_c_select        (alu_c_select),
    .alu_d_select        (alu_d_select),
    .alu_Y1_select       (alu_Y1_select),
    .alu_Y2_select       (alu_Y2_select),
    .alu_write           (alu_write),
    .copy_neg            (copy_neg),
    .copy_select         (copy_select),
    .err_count           (err_count),
    .ext_pending         (ext_pending)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset       = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    instruction = 32'h0;
    tick();
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_err_count", err_count, 0);
    chk("rst_ext_pending", ext_pending, 0);
    chk("rst_alu_write", alu_write, 0);
    chk("rst_constant", constant, 0);
    reset = 1'b0;
    tick();

    // constant add: 0x10C5_2345
    instruction = 32'h10C5_2345;
    in_valid    = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("add_out_valid", out_valid, 1);
    chk("add_constant", constant, 32'h0000_5345);
    chk("add_zero_reg", zero_reg, 4'b1010);
    chk("add_alu_write", alu_write, 2'b01);
    chk("add_vec_perci", alu_vec_perci, 2'b11);
    chk("add_sel_abcd", {alu_a_select, alu_b_select, alu_c_select, alu_d_select}, 16'h2345);
    chk("add_y1y2", {alu_Y1_select, alu_Y2_select}, 8'h24);
    chk("add_invalid", invalid_instruction, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("add_drained", out_valid, 0);
    chk("add_err_count", err_count, 0);

    // add with form=1 and const_c=1 is invalid
    instruction = 32'h1100_1234;
    in_valid    = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("bad_form_invalid", invalid_instruction, 1);
    chk("bad_form_alu_write", alu_write, 2'b00);
    chk("bad_form_err_before", err_count, 0);
    out_ready = 1'b1;
    tick();
    chk("bad_form_err_after", err_count, 1);

    // streaming: push and pop in the same cycle
    instruction = 32'h0000_1030;
    in_valid    = 1'b1;
    tick();
    chk("s1_alu_write", alu_write, 2'b11);
    chk("s1_y1y2", {alu_Y1_select, alu_Y2_select}, 8'h13);
    instruction = 32'h0000_0040;
    tick();
    chk("s2_alu_write", alu_write, 2'b10);
    chk("s2_y1y2", {alu_Y1_select, alu_Y2_select}, 8'h04);
    instruction = 32'h05A0_1234;
    tick();
    chk("s3_copy", {alu_op, copy_neg, copy_select}, {3'b010, 1'b1, 4'hA});
    chk("s3_alu_write", alu_write, 2'b11);
    chk("s3_const", {constant, zero_reg, invalid_instruction}, 37'h0);
    instruction = 32'h0200_1111;
    tick();
    in_valid = 1'b0;
    chk("s4_invalid", {invalid_instruction, alu_op, alu_write}, {1'b1, 3'b001, 2'b00});
    tick();
    chk("s4_drained", out_valid, 0);
    chk("s4_err_count", err_count, 2);

    // fill the 2-deep queue with out_ready low
    out_ready   = 1'b0;
    in_valid    = 1'b1;
    instruction = 32'h0000_1000;
    tick();
    chk("fill1_in_ready", in_ready, 1);
    instruction = 32'h0000_2000;
    tick();
    chk("fill2_in_ready", in_ready, 0);
    instruction = 32'h0000_3000;
    tick();
    chk("fill3_in_ready", in_ready, 0);
    chk("fill3_head", alu_Y1_select, 1);
    out_ready = 1'b1;
    tick();
    chk("drain1_head", alu_Y1_select, 2);
    chk("drain1_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("drain2_head", alu_Y1_select, 3);
    tick();
    chk("drain3_empty", out_valid, 0);

    // extension word (bit 31 set on constant add)
    out_ready   = 1'b0;
    in_valid    = 1'b1;
    instruction = 32'h90C0_0001;
    tick();
`ifdef ALU_DECODE_EXT_CONST_EN
    chk("ext_pending_set", ext_pending, 1);
    chk("ext_nothing_pushed", out_valid, 0);
    instruction = 32'hDEAD_BEEF;
    tick();
    in_valid = 1'b0;
    chk("ext_pending_clear", ext_pending, 0);
    chk("ext_out_valid", out_valid, 1);
    chk("ext_constant", constant, 32'hDEAD_BEEF);
    chk("ext_fields", {zero_reg, alu_write, invalid_instruction}, {4'b1010, 2'b01, 1'b0});
    out_ready = 1'b1;
    tick();
    chk("ext_single_bundle", out_valid, 0);
`else
    in_valid = 1'b0;
    chk("noext_pending", ext_pending, 0);
    chk("noext_constant", constant, 32'h0000_0001);
    chk("noext_fields", {zero_reg, alu_write}, {4'b1010, 2'b01});
    out_ready = 1'b1;
    tick();
    chk("noext_drained", out_valid, 0);
`endif

    // reset with one entry queued (and, in the extension build, a pending extension)
    out_ready   = 1'b0;
    in_valid    = 1'b1;
    instruction = 32'h0000_1000;
    tick();
    instruction = 32'h90C0_0001;
    tick();
    in_valid = 1'b0;
`ifdef ALU_DECODE_EXT_CONST_EN
    chk("pre_rst_ext_pending", ext_pending, 1);
`endif
    chk("pre_rst_out_valid", out_valid, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_ext_pending", ext_pending, 0);
    chk("mid_rst_err_count", err_count, 0);
    chk("mid_rst_alu_write", alu_write, 0);
    tick();
    reset = 1'b0;
    tick();
    instruction = 32'hDEAD_BEEF;
    in_valid    = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("fresh_decode", {invalid_instruction, alu_op, alu_write}, {1'b1, 3'b111, 2'b00});
    chk("fresh_constant", constant, 0);
    chk("fresh_ext_pending", ext_pending, 0);
    out_ready = 1'b1;
    tick();
    chk("fresh_err_count", err_count, 1);

    // saturate the invalid counter: 254 more invalid pops reach 255
    instruction = 32'h0200_1111;
    in_valid    = 1'b1;
    for (int i = 0; i < 254; i++) tick();
    in_valid = 1'b0;
    tick();
    chk("sat_reached", err_count, 8'hFF);
    chk("sat_empty", out_valid, 0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("sat_invalid_head", invalid_instruction, 1);
    tick();
    chk("sat_held", err_count, 8'hFF);
    chk("sat_final_empty", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_decode_stage.md
ALU_DECODE_STAGE -- requirements
Module: alu_decode_stage

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the constant output width; legal range 18..32.
REQ-002 The block SHALL have parameter DEPTH, default 2, giving the output queue depth in entries; power of two, at least 2.
REQ-003 The block SHALL have parameter CNT_W, default 8, giving the invalid-instruction counter width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: the reset, asynchronous and active-high.
REQ-006 The block SHALL have ports in_valid (input, 1), in_ready (output, 1) and instruction (input, 32): the instruction-word handshake.
REQ-007 The block SHALL have ports out_valid (output, 1) and out_ready (input, 1): the decoded-bundle handshake.
REQ-008 The block SHALL have bundle output ports: invalid_instruction 1, alu_op 3, alu_vec_perci 2, alu_form 1, const_c 1, constant DATA_W, zero_reg 4, alu_a/b/c/d_select 4 each, alu_Y1/Y2_select 4 each, alu_write 2, copy_neg 1, copy_select 4.
REQ-009 The block SHALL have port err_count, output, CNT_W bits: the saturating count of invalid instructions emitted.
REQ-010 The block SHALL have port ext_pending, output, 1 bit: high while the block waits for a constant-extension word.

Function
REQ-011 A word SHALL be accepted on a cycle with in_valid and in_ready both high; the same rule applies to bundles on out_valid/out_ready.
REQ-012 in_ready SHALL equal "queue not full"; it SHALL NOT depend on out_ready.
REQ-013 Field map: {const_c, alu_op, alu_form, alu_vec_perci} = instruction[28:22]; {a,b,c,d}_select = instruction[15:0]; Y1 = a_select; Y2 = c_select.
REQ-014 Default bundle: alu_write[0] = (Y1 != 0), alu_write[1] = (Y2 != 0); constant 0; zero_reg 0; copy fields 0; invalid_instruction 0.
REQ-015 Add/sub (op 000 or 100) with form=0 and const_c=1: zero_reg = 4'b1010; alu_write = 2'b01; constant = zero-extended {instruction[21:16], instruction[11:0]}.
REQ-016 Add/sub with form=1 and const_c=1: invalid_instruction = 1 and alu_write = 2'b00.
REQ-017 Copy (op 010): copy_neg = instruction[24]; copy_select = instruction[23:20].
REQ-018 Ops 001, 011, 101, 110 and 111: invalid_instruction = 1 and alu_write = 2'b00.
REQ-019 A decoded bundle SHALL be pushed into the queue in the acceptance cycle and SHALL be visible on out_valid on the next clock edge, giving 1-cycle minimum latency.
REQ-020 The queue SHALL be FIFO-ordered with wrapping pointers; a simultaneous push and pop when full SHALL NOT occur, because in_ready is low when full.
REQ-021 A simultaneous push and pop when non-full SHALL leave the occupancy unchanged.
REQ-022 err_count SHALL increment by 1 when a bundle with invalid_instruction=1 is popped, and SHALL saturate at all-ones.
REQ-023 The output bundle SHALL be driven from queue storage, with no combinational path from instruction to the outputs.

Reset
REQ-024 While reset is high: the queue SHALL be empty, out_valid 0, err_count 0, the FSM IDLE and ext_pending 0.
REQ-025 While reset is high, every bundle output SHALL be 0.
REQ-026 Reset asserted mid-extension SHALL discard the pending instruction.

Configuration
REQ-027 With macro ALU_DECODE_EXT_CONST_EN defined: in the REQ-015 case with instruction[31]=1, the FSM SHALL move IDLE->EXT_WAIT and push nothing.
REQ-028 With ALU_DECODE_EXT_CONST_EN defined: the next accepted word SHALL supply constant = word[DATA_W-1:0]; the held bundle SHALL be pushed with it, and the FSM SHALL return to IDLE.
REQ-029 With ALU_DECODE_EXT_CONST_EN defined: ext_pending SHALL equal (state == EXT_WAIT); in_ready in EXT_WAIT SHALL follow REQ-012.
REQ-030 Without the macro: bit 31 SHALL be ignored, there SHALL be no FSM, and ext_pending SHALL be tied 0.

Structure
REQ-031 A shared package alu_decode_pkg SHALL hold: the op encodings (OP_ADD=000, OP_SUB=100, OP_COPY=010), the field bit positions, ZERO_REG_CONST=4'b1010, the FSM state enum {IDLE, EXT_WAIT}, and the bundle struct type.
REQ-032 The combinational field decode SHALL be one sub-module, alu_decode_comb, mapping 32-bit word -> bundle; the stage instantiates it and owns the FSM, the queue and the counter.

Verification
REQ-033 The bench SHALL drive 0x10C5_2345 (add, const_c=1, form=0); the next-cycle bundle SHALL show constant 0x00005345, zero_reg 1010, alu_write 01.
REQ-034 The bench SHALL drive add, form=1, const_c=1; the bundle SHALL show invalid_instruction=1 and alu_write 00, and err_count SHALL go 0->1 on the pop.
REQ-035 The bench SHALL drive 3 words with out_ready=0 and DEPTH=2; in_ready SHALL drop after 2 accepts, and draining SHALL return the bundles in order.
REQ-036 With ALU_DECODE_EXT_CONST_EN, the bench SHALL drive 0x90C0_0001 then 0xDEAD_BEEF; ext_pending SHALL be 1 for one cycle, and a single bundle with constant 0xDEADBEEF SHALL be emitted.
REQ-037 The bench SHALL assert reset while in EXT_WAIT with 1 entry queued; out_valid, ext_pending and err_count SHALL all be 0 immediately, and the next word SHALL decode as a fresh instruction.
REQ-038 The bench SHALL force err_count to all-ones, then pop an invalid bundle; err_count SHALL stay at all-ones.
